post_ops_unit: RTL and testbench
================================

POST_OPS_UNIT -- requirements
Module: post_ops_unit

Interface
REQ-001 Parameter ACC_W, default 32, signed accumulator input width.
REQ-002 Parameter OUT_BITS, default 8, signed output width (2..ACC_W).
REQ-003 Parameter NUM_CH, default 16, number of per-channel bias entries.
REQ-004 Parameter BIAS_W, default 32, signed bias width (<= ACC_W).
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid / in_ready / in_last  in / out / in  1 each  upstream handshake; in_last marks end of tile.
REQ-008 in_data  in  ACC_W  signed accumulator value.
REQ-009 out_valid / out_ready / out_last  out / in / out  1 each  downstream handshake.
REQ-010 out_data  out  OUT_BITS  signed post-processed result.
REQ-011 cfg_num_ch  in  $clog2(NUM_CH+1)  active channel count (1..NUM_CH); 0 treated as 1.
REQ-012 cfg_shift  in  5  requantisation right-shift amount.
REQ-013 cfg_relu_en / cfg_bypass  in  1 each  ReLU enable; bypass (pass-through mode).
REQ-014 bias_wr_en / bias_wr_addr / bias_wr_data  in  1 / $clog2(NUM_CH) / BIAS_W  bias table write port.

Function
REQ-015 Input beat is accepted when in_valid && in_ready.
REQ-016 Two-stage pipeline; each stage has a valid bit. Stage k advances when its downstream slot is empty or being emptied that cycle.
REQ-017 in_ready = !s1_valid || s2 advancing; s2 advancing = !out_valid || out_ready. No combinational in_valid->out_valid path.
REQ-018 Latency: an accepted beat appears on out_* 2 cycles after acceptance when out_ready is held high; full throughput of 1 beat/cycle.
REQ-019 out_valid, out_data, out_last hold stable while out_valid && !out_ready.
REQ-020 Channel counter ch starts at 0. It increments on each accepted beat and wraps to 0 after cfg_num_ch-1. It forces to 0 after an accepted beat with in_last=1.
REQ-021 Stage 1 captures sum = in_data + sign-extended bias[ch], computed at ACC_W+1 bits. It also captures cfg_shift, cfg_relu_en, cfg_bypass and in_last.
REQ-022 Config inputs affect only beats accepted after the change; beats in flight keep their captured config.
REQ-023 Stage 2, normal mode: apply ReLU (negative -> 0) if enabled. Then arithmetic right shift by shift, rounding half-up: add 2^(shift-1) before shifting when shift>0. Then saturate to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-024 Bypass mode: bias, ReLU and shift skipped; out_data = in_data saturated to OUT_BITS.
REQ-025 A bias write takes effect the cycle after bias_wr_en. A beat accepted in the same cycle as a write to its channel uses the old value.
REQ-026 bias_wr_addr >= NUM_CH: write ignored.
REQ-027 out_last equals the in_last of the same beat; it does not affect data arithmetic.

Reset
REQ-028 rst_n low: pipeline valids, out_valid, out_last and ch cleared to 0, out_data to 0, all bias entries to 0, asynchronously and mid-transfer. In-flight beats are discarded.
REQ-029 in_ready is 1 from the first cycle after rst_n deasserts.

Verification
REQ-030 Bias: bias[0]=100, shift=0, relu=0, in_data=-50, out_ready=1 -> out_data=50, 2 cycles after acceptance.
REQ-031 Rounding/saturation: shift=4; inputs 24, 23, -24, 5000 (bias 0) -> outputs 2, 1, -1, 127 (OUT_BITS=8).
REQ-032 ReLU/bypass: relu=1, in_data=-300 -> 0. bypass=1, in_data=-300 -> -128.
REQ-033 Channel wrap: cfg_num_ch=3, bias={1,2,3}, 7 beats of 0 with in_last on beat 5 -> outputs 1,2,3,1,2,1,2.
REQ-034 Backpressure: stream 10 beats, out_ready random 50% -> no loss, no duplication, order kept, out_* stable while stalled, in_ready low only when both stages full and stalled.
REQ-035 Reset mid-stream with 2 beats in flight -> out_valid 0 next cycle, ch=0, bias table zeroed, next beat processed with bias 0.

Source files
------------

// File: rtl/post_ops_unit.sv
// Accumulator post-processing: per-channel bias add, optional ReLU, rounding
// right shift and saturation to OUT_BITS, in a two-stage valid/ready pipeline.
module post_ops_unit #(
    parameter int ACC_W    = 32,
    parameter int OUT_BITS = 8,
    parameter int NUM_CH   = 16,
    parameter int BIAS_W   = 32,
    localparam int NW      = $clog2(NUM_CH + 1),
    localparam int AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic signed [ACC_W-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic signed [OUT_BITS-1:0] out_data,
    input  logic [NW-1:0]              cfg_num_ch,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu_en,
    input  logic                       cfg_bypass,
    input  logic                       bias_wr_en,
    input  logic [AW-1:0]              bias_wr_addr,
    input  logic signed [BIAS_W-1:0]   bias_wr_data
);

    localparam int SW = ACC_W + 1;
    localparam int WW = ACC_W + 2;
    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

    logic [AW-1:0]              ch_q, ch_d;
    logic signed [BIAS_W-1:0]   bias_q [NUM_CH];
    logic signed [BIAS_W-1:0]   bias_d [NUM_CH];
    logic                       s1_valid_q, s1_valid_d;
    logic signed [SW-1:0]       s1_sum_q, s1_sum_d;
    logic [4:0]                 s1_shift_q, s1_shift_d;
    logic                       s1_relu_q, s1_relu_d;
    logic                       s1_bypass_q, s1_bypass_d;
    logic                       s1_last_q, s1_last_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;

    logic                       s2_adv, accept;
    logic [NW-1:0]              num_eff;
    logic signed [BIAS_W-1:0]   bias_sel;
    logic signed [SW-1:0]       in_ext, bias_ext;
    logic signed [WW-1:0]       val, rnd, rounded;
    logic signed [OUT_BITS-1:0] res;

    // Stage 1: channel tracking, bias add and config capture
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        accept   = in_valid && in_ready;

        num_eff = cfg_num_ch;
        if (cfg_num_ch == '0)
            num_eff = NW'(1);
        else if (int'(cfg_num_ch) > NUM_CH)
            num_eff = NW'(NUM_CH);

        ch_d = ch_q;
        if (accept) begin
            if (in_last || (NW'(ch_q) + NW'(1) >= num_eff))
                ch_d = '0;
            else
                ch_d = ch_q + AW'(1);
        end

        bias_d = bias_q;
        if (bias_wr_en && (int'(bias_wr_addr) < NUM_CH))
            bias_d[bias_wr_addr] = bias_wr_data;

        bias_sel = bias_q[ch_q];
        bias_ext = {{(SW-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel};
        in_ext   = {in_data[ACC_W-1], in_data};

        s1_valid_d  = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
        s1_sum_d    = s1_sum_q;
        s1_shift_d  = s1_shift_q;
        s1_relu_d   = s1_relu_q;
        s1_bypass_d = s1_bypass_q;
        s1_last_d   = s1_last_q;
        if (accept) begin
            // Bypass carries the raw accumulator so stage 2 only saturates it
            s1_sum_d    = cfg_bypass ? in_ext : in_ext + bias_ext;
            s1_shift_d  = cfg_shift;
            s1_relu_d   = cfg_relu_en;
            s1_bypass_d = cfg_bypass;
            s1_last_d   = in_last;
        end
    end

    // Stage 2: ReLU, round-half-up shift, saturate
    always_comb begin
        val     = {s1_sum_q[SW-1], s1_sum_q};
        rnd     = '0;
        rounded = val;
        if (!s1_bypass_q) begin
            if (s1_relu_q && val[WW-1])
                val = '0;
            if (s1_shift_q != 5'd0)
                rnd = WW'(1) <<< (s1_shift_q - 5'd1);
            rounded = (val + rnd) >>> s1_shift_q;
        end

        if (rounded > SAT_MAX)
            res = SAT_MAX[OUT_BITS-1:0];
        else if (rounded < SAT_MIN)
            res = SAT_MIN[OUT_BITS-1:0];
        else
            res = rounded[OUT_BITS-1:0];

        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        out_data_d  = (s2_adv && s1_valid_q) ? res : out_data_q;
        out_last_d  = (s2_adv && s1_valid_q) ? s1_last_q : out_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s1_relu_q   <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                bias_q[i] <= '0;
        end else begin
            ch_q        <= ch_d;
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_shift_q  <= s1_shift_d;
            s1_relu_q   <= s1_relu_d;
            s1_bypass_q <= s1_bypass_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            bias_q      <= bias_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_post_ops_unit.sv
// Directed bench for post_ops_unit: vector table for the arithmetic plus
// hand-written sequences for bias timing, channel wrap, backpressure and reset.
module tb_post_ops_unit;

    localparam int NUM_CH = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic signed [31:0] in_data = '0;
    logic out_valid, out_ready = 1'b1, out_last;
    logic signed [7:0] out_data;
    logic [3:0] cfg_num_ch = 4'd1;
    logic [4:0] cfg_shift = '0;
    logic cfg_relu_en = 1'b0, cfg_bypass = 1'b0;
    logic bias_wr_en = 1'b0;
    logic [3:0] bias_wr_addr = '0;
    logic signed [31:0] bias_wr_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int got_d[$];
    int got_l[$];
    bit stall_prev = 1'b0;
    logic signed [7:0] prev_data;
    logic prev_last;

    post_ops_unit #(.ACC_W(32), .OUT_BITS(8), .NUM_CH(NUM_CH), .BIAS_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_data(out_data),
        .cfg_num_ch(cfg_num_ch), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
        .cfg_bypass(cfg_bypass), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
        .bias_wr_data(bias_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (!in_ready)
                chk("ready_low_only_when_stalled", out_valid && !out_ready, 1);
            if (out_valid && out_ready) begin
                got_d.push_back(int'(out_data));
                got_l.push_back(int'(out_last));
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic send(input int d, input logic l);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wr_bias(input int a, input int v);
        bias_wr_en   = 1'b1;
        bias_wr_addr = 4'(a);
        bias_wr_data = v;
        tick();
        bias_wr_en   = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got_d.size() < n && c < 200) begin
            @(negedge clk);
            c++;
        end
        tick();
        chk("out_count", got_d.size(), n);
    endtask

    // Single beat with out_ready high: checks 2-cycle latency and value.
    task automatic run_one(input string name, input int d, input int exp);
        int n = 0;
        send(d, 1'b0);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk({name, "_latency"}, n, 2);
        chk(name, out_data, exp);
        chk({name, "_last"}, out_last, 0);
        tick();
    endtask

    typedef struct {
        string      nm;
        logic [4:0] sh;
        logic       relu;
        logic       byp;
        int         din;
        int         exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"rnd_24",     5'd4, 1'b0, 1'b0,   24,    2};
        vecs[1]  = '{"rnd_23",     5'd4, 1'b0, 1'b0,   23,    1};
        vecs[2]  = '{"rnd_m24",    5'd4, 1'b0, 1'b0,  -24,   -1};
        vecs[3]  = '{"sat_5000",   5'd4, 1'b0, 1'b0, 5000,  127};
        vecs[4]  = '{"relu_m300",  5'd0, 1'b1, 1'b0, -300,    0};
        vecs[5]  = '{"byp_m300",   5'd0, 1'b0, 1'b1, -300, -128};
        vecs[6]  = '{"sat_m200",   5'd0, 1'b0, 1'b0, -200, -128};
        vecs[7]  = '{"rnd_3_sh1",  5'd1, 1'b0, 1'b0,    3,    2};
        vecs[8]  = '{"rnd_m3_sh1", 5'd1, 1'b0, 1'b0,   -3,   -1};
        vecs[9]  = '{"relu_pos",   5'd2, 1'b1, 1'b0,   10,    3};
        vecs[10] = '{"byp_100",    5'd9, 1'b1, 1'b1,  100,  100};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        tick();

        // Bias add on channel 0
        cfg_num_ch = 4'd1;
        wr_bias(0, 100);
        run_one("bias_100", -50, 50);
        wr_bias(0, 0);

        foreach (vecs[i]) begin
            cfg_shift   = vecs[i].sh;
            cfg_relu_en = vecs[i].relu;
            cfg_bypass  = vecs[i].byp;
            run_one(vecs[i].nm, vecs[i].din, vecs[i].exp);
        end
        cfg_shift = '0; cfg_relu_en = 1'b0; cfg_bypass = 1'b0;

        // Write in the acceptance cycle: that beat sees the old bias
        got_d.delete(); got_l.delete();
        bias_wr_en = 1'b1; bias_wr_addr = 4'd0; bias_wr_data = 7;
        send(10, 1'b0);
        bias_wr_en = 1'b0;
        send(10, 1'b0);
        wait_got(2);
        if (got_d.size() >= 2) begin
            chk("same_cycle_old_bias", got_d[0], 10);
            chk("next_beat_new_bias", got_d[1], 17);
        end
        wr_bias(0, 0);

        // Out-of-range addresses leave channel 0 untouched
        got_d.delete(); got_l.delete();
        wr_bias(12, 55);
        wr_bias(15, 66);
        send(4, 1'b0);
        wait_got(1);
        if (got_d.size() >= 1) chk("oob_write_ignored", got_d[0], 4);

        // Backpressure: random out_ready, order and count preserved
        got_d.delete(); got_l.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) send(i * 7 - 30, i == 9);
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_got(10);
        for (int i = 0; i < got_d.size() && i < 10; i++) begin
            chk($sformatf("bp_data_%0d", i), got_d[i], i * 7 - 30);
            chk($sformatf("bp_last_%0d", i), got_l[i], (i == 9) ? 1 : 0);
        end

        // Channel wrap with early in_last
        got_d.delete(); got_l.delete();
        cfg_num_ch = 4'd3;
        wr_bias(0, 1); wr_bias(1, 2); wr_bias(2, 3);
        for (int i = 0; i < 7; i++) send(0, i == 4);
        wait_got(7);
        begin
            int exp_w[7] = '{1, 2, 3, 1, 2, 1, 2};
            for (int i = 0; i < got_d.size() && i < 7; i++) begin
                chk($sformatf("wrap_data_%0d", i), got_d[i], exp_w[i]);
                chk($sformatf("wrap_last_%0d", i), got_l[i], (i == 4) ? 1 : 0);
            end
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(0, 1'b0);
        send(0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_last", out_last, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        got_d.delete(); got_l.delete();
        tick();
        wr_bias(1, 6); wr_bias(2, 7);
        send(0, 1'b0);
        send(0, 1'b0);
        wait_got(2);
        if (got_d.size() >= 2) begin
            chk("post_rst_ch0_bias0", got_d[0], 0);
            chk("post_rst_ch1", got_d[1], 6);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
